// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice per clock,
// operands captured on the input handshake, result held until the output handshake.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Returns {c3, c2, s[3:0]}; c2 is the carry into the slice MSB.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic       c0;
        logic       c1;
        logic       c2;
        logic       c3;
        g  = x & y;
        p  = x ^ y;
        c0 = g[0] | (p[0] & ci);
        c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c3, c2, p ^ {c2, c1, c0, ci}};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic [IW+1:0]    off_s;
    logic [5:0]       slice_s;

    assign off_s   = {idx_r, 2'b00};
    assign slice_s = cla4(a_r[off_s +: 4], b_r[off_s +: 4], carry_r);

    // Next-state decode and per-cycle action strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, handshake flags, operand capture and nibble datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= sub ? 1'b1 : cin;
                idx_r   <= '0;
            end else if (step_s) begin
                sum_r[off_s +: 4] <= slice_s[3:0];
                carry_r           <= slice_s[5];
                idx_r             <= idx_r + IDX_ONE;
                if (last_s) begin
                    cout_r <= slice_s[5];
                    ovf_r  <= slice_s[5] ^ slice_s[4];
                end else begin
                    cout_r <= cout_r;
                    ovf_r  <= ovf_r;
                end
            end else begin
                carry_r <= carry_r;
                idx_r   <= idx_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed vector table, DONE-hold and
// mid-run reset sequences, then random operations against an arithmetic model.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp;
    int n_fail;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic ci,
                                  input logic sb, output logic [15:0] s, output logic co,
                                  output logic ov);
        int sx;
        int sy;
        int r;
        int u;
        sx = $signed(x);
        sy = $signed(y);
        if (sb) begin
            s  = x - y;
            co = (x >= y);
            r  = sx - sy;
        end else begin
            u  = int'(x) + int'(y) + int'(ci);
            s  = u[15:0];
            co = (u > 65535);
            r  = sx + sy + int'(ci);
        end
        ov = (r > 32767) || (r < -32768);
    endfunction

    // Enters at a negedge in IDLE; returns at the negedge where out_valid is high.
    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                            input logic xs);
        int edges;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 12) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", edges, 32'd4);
    endtask

    task automatic check_result(input logic [15:0] s, input logic co, input logic ov);
        chk("sum", {16'd0, sum}, {16'd0, s});
        chk("cout", {31'd0, cout}, {31'd0, co});
        chk("ovf", {31'd0, ovf}, {31'd0, ov});
    endtask

    task automatic finish_op(input logic [15:0] s);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_clr", {31'd0, out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("sum_retained", {16'd0, sum}, {16'd0, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] es;
        logic        eco;
        logic        eov;
        int          seen;

        n_cmp = 0;
        n_fail = 0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            check_result(vecs[i].s, vecs[i].co, vecs[i].ov);
            finish_op(vecs[i].s);
        end

        // Hold in DONE with in_valid high and inputs changing.
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            check_result(16'h1000, 1'b0, 1'b0);
        end
        in_valid = 1'b1;
        finish_op(16'h1000);

        // Reset in the middle of RUN.
        start_op_partial: begin
            @(negedge clk);
            a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_sum", {16'd0, sum}, 32'd0);
            chk("midrst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen++;
            end
            chk("midrst_no_result", seen, 32'd0);
        end
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        check_result(16'h5555, 1'b0, 1'b0);
        finish_op(16'h5555);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic        rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rc, rs, es, eco, eov);
            start_op(ra, rb, rc, rs);
            check_result(es, eco, eov);
            finish_op(es);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
